// File: rtl/seg7_bus_display_if.sv
// rtl/seg7_bus_display_if.sv - CPU bus bundle for the seven-segment display controller
interface seg7_bus_display_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/seg7_bus_display.sv
// rtl/seg7_bus_display.sv - memory-mapped 4-digit multiplexed seven-segment display
module seg7_bus_display #(
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter int          REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  seg7_bus_display_if.slave   bus,
  output logic [6:0]          segments,
  output logic                decimal_point,
  output logic [3:0]          anode
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [7:0]       digits_lo;
  logic [7:0]       digits_hi;
  logic [7:0]       ctrl;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [15:0] offset;
  logic        in_win;
  logic [7:0]  rd_mux;
  logic [3:0]  cur_digit;
  logic        cur_dp;
  logic        cur_blank;

  // Subtracting the base keeps the decode correct for unaligned BASE_ADDR too.
  assign offset = bus.addr - BASE_ADDR;
  assign in_win = (offset[15:2] == 14'd0);

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  always_comb begin
    rd_mux = 8'h00;
    case (offset[1:0])
      2'd0:    rd_mux = digits_lo;
      2'd1:    rd_mux = digits_hi;
      2'd2:    rd_mux = ctrl;
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    cur_digit = 4'h0;
    case (idx)
      2'd0:    cur_digit = digits_lo[3:0];
      2'd1:    cur_digit = digits_lo[7:4];
      2'd2:    cur_digit = digits_hi[3:0];
      default: cur_digit = digits_hi[7:4];
    endcase
    cur_dp    = ctrl[idx];
    cur_blank = ctrl[{2'b01, idx}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_lo     <= 8'h00;
      digits_hi     <= 8'h00;
      ctrl          <= 8'h00;
      cnt           <= '0;
      idx           <= 2'd0;
      bus.rdata     <= 8'h00;
      anode         <= 4'b1111;
      segments      <= 7'h7F;
      decimal_point <= 1'b1;
    end else begin
      if (bus.we && in_win) begin
        case (offset[1:0])
          2'd0:    digits_lo <= bus.wdata;
          2'd1:    digits_hi <= bus.wdata;
          2'd2:    ctrl      <= bus.wdata;
          default: ;
        endcase
      end

      bus.rdata <= in_win ? rd_mux : 8'h00;

      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Outputs image the pre-edge idx and registers, so a same-edge write shows one edge later.
      anode         <= cur_blank ? 4'b1111 : ~(4'b0001 << idx);
      segments      <= font(cur_digit);
      decimal_point <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seg7_bus_display.sv
// tb/tb_seg7_bus_display.sv - directed self-checking bench for seg7_bus_display
module tb_seg7_bus_display;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic [6:0] segments;
  logic       decimal_point;
  logic [3:0] anode;

  int n_assert;
  int n_fail;
  int e;
  int guard;
  int s;

  logic [3:0] anode_tab [4];
  logic [6:0] seg_tab   [4];

  seg7_bus_display_if bus_if ();

  seg7_bus_display #(
    .BASE_ADDR   (16'h2000),
    .REFRESH_DIV (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_if),
    .segments      (segments),
    .decimal_point (decimal_point),
    .anode         (anode)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    e++;
  endtask

  function automatic int slot_of(input int edge_n);
    return ((edge_n - 1) / 4) % 4;
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.we    = 1'b1;
    step();
    bus_if.we    = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus_if.addr = a;
    bus_if.we   = 1'b0;
    step();
    chk(tag, bus_if.rdata, exp);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    e        = 0;
    clk      = 1'b0;
    clk_en   = 1'b0;
    reset    = 1'b0;
    bus_if.addr  = 16'h0000;
    bus_if.wdata = 8'h00;
    bus_if.we    = 1'b0;
    anode_tab[0] = 4'hE; anode_tab[1] = 4'hD; anode_tab[2] = 4'hB; anode_tab[3] = 4'h7;
    seg_tab[0] = 7'h24; seg_tab[1] = 7'h79; seg_tab[2] = 7'h19; seg_tab[3] = 7'h30;

    // Reset with the clock stopped
    #1 reset = 1'b1;
    #10;
    chk("rst_anode", {4'h0, anode}, 8'h0F);
    chk("rst_seg",   {1'b0, segments}, 8'h7F);
    chk("rst_dp",    {7'h0, decimal_point}, 8'h01);
    chk("rst_rdata", bus_if.rdata, 8'h00);
    reset = 1'b0;
    #1 clk_en = 1'b1;

    step();
    chk("first_anode", {4'h0, anode}, 8'h0E);
    chk("first_seg",   {1'b0, segments}, 8'h40);
    chk("first_dp",    {7'h0, decimal_point}, 8'h01);

    // Scan order and 4-clock hold per slot
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("scan_anode_e%0d", e), {4'h0, anode}, {4'h0, anode_tab[slot_of(e)]});
    end

    // Digits 2,1,4,3
    bus_write(16'h2000, 8'h12);
    bus_write(16'h2001, 8'h34);
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("digit_seg_e%0d", e), {1'b0, segments}, {1'b0, seg_tab[slot_of(e)]});
    end

    // Write to digit 0 while slot 0 is on the pins
    guard = 0;
    while (!(slot_of(e + 1) == 0 && slot_of(e + 2) == 0) && guard < 20) begin
      step();
      guard++;
    end
    chk("find_slot0", {7'h0, guard < 20}, 8'h01);
    bus_write(16'h2000, 8'h05);
    chk("same_edge_old", {1'b0, segments}, 8'h24);
    step();
    chk("same_edge_new", {1'b0, segments}, 8'h12);

    // Blank digit 1, decimal point on digit 0
    bus_write(16'h2002, 8'h21);
    step();
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      s = slot_of(e);
      chk($sformatf("blank_anode_e%0d", e), {4'h0, anode}, (s == 1) ? 8'h0F : {4'h0, anode_tab[s]});
      chk($sformatf("dp_e%0d", e), {7'h0, decimal_point}, (s == 0) ? 8'h00 : 8'h01);
    end

    // Readback and out-of-window accesses
    bus_read("rd_base1", 16'h2001, 8'h34);
    bus_read("rd_base3", 16'h2003, 8'h00);
    bus_read("rd_base4", 16'h2004, 8'h00);
    bus_read("rd_base2", 16'h2002, 8'h21);
    bus_write(16'h2004, 8'hFF);
    bus_write(16'h1FFF, 8'hFF);
    bus_read("rd_after_oob0", 16'h2000, 8'h05);
    bus_read("rd_after_oob1", 16'h2001, 8'h34);
    bus_read("rd_after_oob2", 16'h2002, 8'h21);
    bus_read("rd_oob_low",    16'h1FFF, 8'h00);

    // Asynchronous reset mid-scan while idx is 2
    guard = 0;
    while (!(slot_of(e) == 2 && slot_of(e + 1) == 2) && guard < 20) begin
      step();
      guard++;
    end
    chk("find_idx2", {7'h0, guard < 20}, 8'h01);
    chk("pre_rst_anode", {4'h0, anode}, 8'h0B);
    bus_if.addr = 16'h2000;
    #1 reset = 1'b1;
    #1;
    chk("async_anode", {4'h0, anode}, 8'h0F);
    chk("async_seg",   {1'b0, segments}, 8'h7F);
    chk("async_dp",    {7'h0, decimal_point}, 8'h01);
    chk("async_rdata", bus_if.rdata, 8'h00);
    reset = 1'b0;
    e = 0;
    step();
    chk("restart_anode", {4'h0, anode}, 8'h0E);
    chk("restart_seg",   {1'b0, segments}, 8'h40);
    chk("restart_rdata", bus_if.rdata, 8'h00);
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("zero_anode_e%0d", e), {4'h0, anode}, {4'h0, anode_tab[slot_of(e)]});
      chk($sformatf("zero_seg_e%0d", e), {1'b0, segments}, 8'h40);
      chk($sformatf("zero_dp_e%0d", e), {7'h0, decimal_point}, 8'h01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
